lcb_rq_decoder: RTL and testbench
=================================

// Module: lcb_rq_decoder
// PURPOSE
//  Frame decoder between UART_RX and the request/answer logic of the LCB simulator.
//  - Consumes the byte stream (strobe + 8-bit data) produced by UART_RX.
//  - Parses 4-byte request frames: SYNC, ADDR, CMD, CHK.
//  - Emits a one-cycle request pulse with the latched ADDR/CMD, plus error pulses.
//  - The downstream answer/TX logic is driven from the validated request instead of raw bytes.
// PARAMETERS
//  SYNC_BYTE    8'hA5   first byte of every frame
//  DEV_ADDR     8'h01   own device address
//  BCAST_ADDR   8'hFF   broadcast address, always accepted
//  CHK_SEED     8'h5A   checksum seed: CHK = ADDR ^ CMD ^ CHK_SEED
//  TIMEOUT_CYC  8000    max clk cycles allowed between bytes inside a frame
//  TO_W         14      timeout counter width; 2**TO_W > TIMEOUT_CYC
// PORTS
//  clk           in   1   system clock (80 MHz)
//  rst           in   1   synchronous reset, active high
//  strob         in   1   byte-valid strobe from UART_RX, one cycle per byte
//  data_in       in   8   received byte, valid while strob=1
//  rq_valid      out  1   one-cycle pulse: good frame addressed to this device
//  rq_addr       out  8   ADDR of the last good frame
//  rq_cmd        out  8   CMD of the last good frame
//  rq_bcast      out  1   1 = last good frame used BCAST_ADDR
//  err_chk       out  1   one-cycle pulse: checksum mismatch
//  err_timeout   out  1   one-cycle pulse: inter-byte timeout inside a frame
//  busy          out  1   1 while state != IDLE
//  frame_cnt     out  16  good-frame counter (RQ_STATS_EN only, else 0)
//  err_cnt       out  16  error counter (RQ_STATS_EN only, else 0)
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; timeout counter=0; internal ADDR/CMD latches=0.
//  States: IDLE -> S_ADDR -> S_CMD -> S_CHK -> IDLE.
//  - IDLE: on strob with data_in==SYNC_BYTE, go to S_ADDR. Any other byte is ignored.
//  - S_ADDR: on strob, latch addr_r, go to S_CMD. A byte equal to SYNC_BYTE is treated as
//    ADDR; there is no resync.
//  - S_CMD: on strob, latch cmd_r, go to S_CHK.
//  - S_CHK: on strob, go to IDLE and evaluate the frame:
//    - data_in != addr_r^cmd_r^CHK_SEED: err_chk=1 for the next cycle; rq_* unchanged.
//    - checksum OK and addr_r is DEV_ADDR or BCAST_ADDR: in the next cycle rq_valid=1,
//      rq_addr/rq_cmd/rq_bcast updated.
//    - checksum OK, foreign address: dropped silently, no pulse.
//  Latency: rq_valid/err_chk are registered, 1 clk after the CHK-byte strobe.
//  rq_addr/rq_cmd/rq_bcast hold their values until the next good frame.
//  Timeout counter:
//  - Cleared on every accepted strob and while in IDLE.
//  - Counts up in the other states; saturates and does not wrap.
//  - When it reaches TIMEOUT_CYC-1 with no strob in that cycle: go to IDLE, err_timeout=1
//    for the next cycle.
//  Simultaneous strob and timeout in the same cycle: the strob wins (byte accepted, no error).
//  A strob in the cycle rq_valid is high is processed normally; back-to-back frames with no gap
//  are supported.
//  rst mid-frame: partial frame discarded, no pulses; rq_* outputs cleared to 0.
//  busy = (state != IDLE), combinational from the state register.
// CONFIGURATION
//  RQ_STATS_EN defined:
//  - frame_cnt increments on each rq_valid.
//  - err_cnt increments on each err_chk or err_timeout.
//  - Both are 16-bit, saturate at 16'hFFFF and reset to 0.
//  RQ_STATS_EN undefined: no counter logic; frame_cnt and err_cnt are tied to 16'h0000.
//  The port list is identical in both builds.
// TESTING
//  1. Bytes A5,01,10,4B (01^10^5A=4B) -> rq_valid pulse 1 clk after the 4th strob;
//     rq_addr=01, rq_cmd=10, rq_bcast=0.
//  2. Bytes A5,FF,22,87 -> rq_valid, rq_addr=FF, rq_bcast=1.
//     Bytes A5,07,22,7F (foreign address) -> no pulses.
//  3. Bytes A5,01,10,00 -> err_chk pulse, no rq_valid, rq_cmd keeps its previous value.
//  4. A5,01, then 8000 idle clks -> err_timeout pulse, busy=0.
//     Then A5,01,10,4B -> rq_valid.
//  5. Garbage 00,37,A4, then A5,01,33,68 with zero gap -> exactly one rq_valid, rq_cmd=33.
//  6. rst after A5,01 -> busy=0, outputs 0; then a full good frame -> rq_valid.
//     With RQ_STATS_EN: after tests 1-5, frame_cnt=4 and err_cnt=2.

Source files
------------

// File: rtl/lcb_rq_decoder.sv
// lcb_rq_decoder: 4-byte request frame parser (SYNC, ADDR, CMD, CHK) behind UART_RX.
// Optional RQ_STATS_EN adds saturating good-frame / error counters.
module lcb_rq_decoder #(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter logic [7:0] DEV_ADDR    = 8'h01,
   parameter logic [7:0] BCAST_ADDR  = 8'hFF,
   parameter logic [7:0] CHK_SEED    = 8'h5A,
   parameter int         TIMEOUT_CYC = 8000,
   parameter int         TO_W        = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        strob,
   input  logic [7:0]  data_in,
   output logic        rq_valid,
   output logic [7:0]  rq_addr,
   output logic [7:0]  rq_cmd,
   output logic        rq_bcast,
   output logic        err_chk,
   output logic        err_timeout,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [15:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      S_ADDR,
      S_CMD,
      S_CHK
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_t          state;
   state_t          state_nx;
   logic [7:0]      addr_r;
   logic [7:0]      addr_nx;
   logic [7:0]      cmd_r;
   logic [7:0]      cmd_nx;
   logic [TO_W-1:0] to_cnt;
   logic [TO_W-1:0] to_nx;
   logic            to_hit;
   logic            chk_ok;
   logic            addr_ok;
   logic            rq_valid_nx;
   logic [7:0]      rq_addr_nx;
   logic [7:0]      rq_cmd_nx;
   logic            rq_bcast_nx;
   logic            err_chk_nx;
   logic            err_to_nx;

   assign to_hit  = (to_cnt == TO_LAST);
   assign chk_ok  = (data_in == (addr_r ^ cmd_r ^ CHK_SEED));
   assign addr_ok = (addr_r == DEV_ADDR) || (addr_r == BCAST_ADDR);
   assign busy    = (state != IDLE);

   // State, field latches, timeout counter and registered result pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr_r      <= '0;
         cmd_r       <= '0;
         to_cnt      <= '0;
         rq_valid    <= 1'b0;
         rq_addr     <= '0;
         rq_cmd      <= '0;
         rq_bcast    <= 1'b0;
         err_chk     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nx;
         addr_r      <= addr_nx;
         cmd_r       <= cmd_nx;
         to_cnt      <= to_nx;
         rq_valid    <= rq_valid_nx;
         rq_addr     <= rq_addr_nx;
         rq_cmd      <= rq_cmd_nx;
         rq_bcast    <= rq_bcast_nx;
         err_chk     <= err_chk_nx;
         err_timeout <= err_to_nx;
      end
   end

   // Frame walk; a strob in the timeout cycle wins over the timeout
   always_comb begin
      state_nx    = state;
      addr_nx     = addr_r;
      cmd_nx      = cmd_r;
      rq_valid_nx = 1'b0;
      rq_addr_nx  = rq_addr;
      rq_cmd_nx   = rq_cmd;
      rq_bcast_nx = rq_bcast;
      err_chk_nx  = 1'b0;
      err_to_nx   = 1'b0;
      unique case (state)
         IDLE: begin
            if (strob && (data_in == SYNC_BYTE)) begin
               state_nx = S_ADDR;
            end
         end
         S_ADDR: begin
            if (strob) begin
               addr_nx  = data_in;
               state_nx = S_CMD;
            end else if (to_hit) begin
               state_nx  = IDLE;
               err_to_nx = 1'b1;
            end
         end
         S_CMD: begin
            if (strob) begin
               cmd_nx   = data_in;
               state_nx = S_CHK;
            end else if (to_hit) begin
               state_nx  = IDLE;
               err_to_nx = 1'b1;
            end
         end
         S_CHK: begin
            if (strob) begin
               state_nx = IDLE;
               if (!chk_ok) begin
                  err_chk_nx = 1'b1;
               end else if (addr_ok) begin
                  rq_valid_nx = 1'b1;
                  rq_addr_nx  = addr_r;
                  rq_cmd_nx   = cmd_r;
                  rq_bcast_nx = (addr_r == BCAST_ADDR);
               end
            end else if (to_hit) begin
               state_nx  = IDLE;
               err_to_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Inter-byte timer: zero in IDLE and on each byte, saturating otherwise
   always_comb begin
      to_nx = to_cnt;
      if ((state == IDLE) || strob || (state_nx == IDLE)) begin
         to_nx = '0;
      end else if (to_cnt != '1) begin
         to_nx = to_cnt + 1'b1;
      end
   end

`ifdef RQ_STATS_EN
   // Saturating good-frame and error counters
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (rq_valid && (frame_cnt != 16'hFFFF)) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         if ((err_chk || err_timeout) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
         end
      end
   end
`else
   assign frame_cnt = 16'h0000;
   assign err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_lcb_rq_decoder.sv
// tb_lcb_rq_decoder: directed + random byte streams checked every cycle
// against a queue-based frame model.
module tb_lcb_rq_decoder;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam logic [7:0] DEV  = 8'h01;
   localparam logic [7:0] BC   = 8'hFF;
   localparam logic [7:0] SEED = 8'h5A;
   localparam int         TMO  = 8000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        strob = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic        rq_valid;
   logic [7:0]  rq_addr;
   logic [7:0]  rq_cmd;
   logic        rq_bcast;
   logic        err_chk;
   logic        err_timeout;
   logic        busy;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;

   int total = 0;
   int bad   = 0;

   logic [7:0] mq[$];
   int         waited;
   logic       e_valid, e_chk, e_to, e_bcast;
   logic [7:0] e_addr, e_cmd;
   int         e_fcnt, e_ecnt;
   int         long_left;

   lcb_rq_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .strob       (strob),
      .data_in     (data_in),
      .rq_valid    (rq_valid),
      .rq_addr     (rq_addr),
      .rq_cmd      (rq_cmd),
      .rq_bcast    (rq_bcast),
      .err_chk     (err_chk),
      .err_timeout (err_timeout),
      .busy        (busy),
      .frame_cnt   (frame_cnt),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ck(input logic [7:0] a, input logic [7:0] c);
      return a ^ c ^ SEED;
   endfunction

   // Reference: collect bytes from a SYNC onward, judge at four bytes
   task automatic model(input logic r, input logic s, input logic [7:0] d);
      logic nv, nc, nt;
      logic [7:0] a, c, k;
      nv = 1'b0; nc = 1'b0; nt = 1'b0;
      if (r) begin
         mq.delete();
         waited = 0;
         e_addr = 8'h00; e_cmd = 8'h00; e_bcast = 1'b0;
         e_fcnt = 0; e_ecnt = 0;
      end else begin
         if (s) begin
            waited = 0;
            if (mq.size() != 0 || d == SYNC) mq.push_back(d);
            if (mq.size() == 4) begin
               a = mq[1]; c = mq[2]; k = mq[3];
               mq.delete();
               if (k != ck(a, c)) nc = 1'b1;
               else if (a == DEV || a == BC) begin
                  nv = 1'b1;
                  e_addr = a; e_cmd = c; e_bcast = (a == BC);
               end
            end
         end else if (mq.size() != 0) begin
            waited++;
            if (waited == TMO) begin
               nt = 1'b1;
               mq.delete();
               waited = 0;
            end
         end
`ifdef RQ_STATS_EN
         if (e_valid && e_fcnt < 65535) e_fcnt++;
         if ((e_chk || e_to) && e_ecnt < 65535) e_ecnt++;
`endif
      end
      e_valid = nv; e_chk = nc; e_to = nt;
   endtask

   task automatic step(input logic r, input logic s, input logic [7:0] d);
      rst = r; strob = s; data_in = d;
      @(posedge clk);
      model(r, s, d);
      #1;
      check("rq_valid", 16'(rq_valid), 16'(e_valid));
      check("err_chk", 16'(err_chk), 16'(e_chk));
      check("err_timeout", 16'(err_timeout), 16'(e_to));
      check("rq_addr", 16'(rq_addr), 16'(e_addr));
      check("rq_cmd", 16'(rq_cmd), 16'(e_cmd));
      check("rq_bcast", 16'(rq_bcast), 16'(e_bcast));
      check("busy", 16'(busy), 16'(mq.size() != 0));
      check("frame_cnt", frame_cnt, 16'(e_fcnt));
      check("err_cnt", err_cnt, 16'(e_ecnt));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send(input logic [7:0] b, input int gmax);
      step(1'b0, 1'b1, b);
      idle($urandom_range(0, gmax));
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] c,
                        input logic [7:0] k, input int gmax);
      send(SYNC, gmax); send(a, gmax); send(c, gmax); send(k, gmax);
   endtask

   initial begin
      e_valid = 0; e_chk = 0; e_to = 0;
      long_left = 2;
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      // directed scenarios
      frame(8'h01, 8'h10, 8'h4B, 0); idle(2);
      frame(8'hFF, 8'h22, 8'h87, 0); idle(2);
      frame(8'h07, 8'h22, 8'h7F, 0); idle(2);
      frame(8'h01, 8'h10, 8'h00, 0); idle(2);
      send(SYNC, 0); send(8'h01, 0); idle(TMO + 3);
      frame(8'h01, 8'h10, 8'h4B, 0); idle(2);
      send(8'h00, 0); send(8'h37, 0); send(8'hA4, 0);
      frame(8'h01, 8'h33, 8'h68, 0); idle(2);
      send(SYNC, 0); send(8'h01, 0);
      step(1'b1, 1'b0, 8'h00);
      frame(8'h01, 8'h10, 8'h4B, 0); idle(2);
      // byte arriving in the last allowed cycle is accepted
      send(SYNC, 0); send(8'h01, 0); idle(TMO - 1);
      send(8'h10, 0); send(8'h4B, 0); idle(2);
      // back-to-back frames
      frame(8'hFF, 8'h5C, ck(8'hFF, 8'h5C), 0);
      frame(8'h01, 8'h99, ck(8'h01, 8'h99), 0); idle(1);
      // random traffic
      for (int n = 0; n < 300; n++) begin
         logic [7:0] a, c;
         int k;
         k = $urandom_range(0, 9);
         c = 8'($urandom);
         a = 8'($urandom);
         case (k)
            0, 1, 2: frame(DEV, c, ck(DEV, c), 3);
            3: frame(BC, c, ck(BC, c), 3);
            4: frame((a == DEV || a == BC) ? 8'h42 : a, c,
                     ck((a == DEV || a == BC) ? 8'h42 : a, c), 3);
            5: frame(DEV, c, ck(DEV, c) ^ 8'h01, 3);
            6: for (int i = 0; i < 3; i++) send(8'($urandom), 2);
            7: frame(a, c, 8'($urandom), 2);
            8: begin
               send(SYNC, 1); send(a, 1);
               step(1'b1, 1'b0, 8'h00);
            end
            default: begin
               if (long_left > 0) begin
                  long_left--;
                  send(SYNC, 0); send(DEV, 0);
                  idle(TMO + $urandom_range(0, 5));
               end else begin
                  frame(DEV, c, ck(DEV, c), 0);
               end
            end
         endcase
      end
      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
